// File: rtl/cmplx_fx_pkg.sv
// Shared widths, FSM states and partial-product ordering for the complex
// multiplier front end.
package cmplx_fx_pkg;

  localparam int IW = 16;       // operand width, Q5.11
  localparam int IF = 11;       // operand fractional bits
  localparam int IH = IW - IF;  // operand integer bits incl. sign
  localparam int PW = 2 * IW;   // full-precision product width, Q10.22
  localparam int OW = PW;       // output width handed to the combine stage

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] idx_t;

  // Order in which the shared multiplier produces the partial products
  localparam idx_t IDX_A1B1 = 2'd0;
  localparam idx_t IDX_A2B2 = 2'd1;
  localparam idx_t IDX_A1B2 = 2'd2;
  localparam idx_t IDX_A2B1 = 2'd3;
  localparam idx_t IDX_LAST = IDX_A2B1;

endpackage

// File: rtl/fx_mul_signed.sv
// Combinational full-precision signed multiplier; the binary point is tracked
// by the caller, so the product keeps all 2*W bits.
module fx_mul_signed
  import cmplx_fx_pkg::*;
(
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  output logic signed [PW-1:0] p
);

  assign p = x * y;

endmodule

// File: rtl/cmplx_partial_products.sv
// Complex multiplier front end: latches a and b, then forms a1b1, a2b2, a1b2,
// a2b1 one per cycle on a single shared multiplier.
module cmplx_partial_products
  import cmplx_fx_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IH-1:-IF]      a1,
  input  logic signed [IH-1:-IF]      a2,
  input  logic signed [IH-1:-IF]      b1,
  input  logic signed [IH-1:-IF]      b2,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [2*IH-1:-2*IF]  a1b1,
  output logic signed [2*IH-1:-2*IF]  a2b2,
  output logic signed [2*IH-1:-2*IF]  a1b2,
  output logic signed [2*IH-1:-2*IF]  a2b1,
  output logic                        out_valid,
  input  logic                        out_ready,
  output state_t                      dbg_state
);

  state_t state, state_n;
  idx_t   idx;

  logic signed [IH-1:-IF] a1_q, a2_q, b1_q, b2_q;
  logic signed [IW-1:0]   op_x, op_y;
  logic signed [PW-1:0]   mul_p;
  logic                   accept;

  // Handshake: a transfer happens on the posedge where valid && ready are both
  // high; valid may not depend on ready, but in_ready looks through to
  // out_ready so a finished result and a new operand set swap in one edge.
  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = MUL;
      MUL:     if (idx == IDX_LAST) state_n = DONE;
      DONE:    if (out_ready) state_n = in_valid ? MUL : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    op_x = a1_q;
    op_y = b1_q;
    case (idx)
      IDX_A1B1: begin op_x = a1_q; op_y = b1_q; end
      IDX_A2B2: begin op_x = a2_q; op_y = b2_q; end
      IDX_A1B2: begin op_x = a1_q; op_y = b2_q; end
      IDX_A2B1: begin op_x = a2_q; op_y = b1_q; end
      default:  begin op_x = a1_q; op_y = b1_q; end
    endcase
  end

  fx_mul_signed u_mul (
    .x (op_x),
    .y (op_y),
    .p (mul_p)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      a1_q  <= '0;
      a2_q  <= '0;
      b1_q  <= '0;
      b2_q  <= '0;
      a1b1  <= '0;
      a2b2  <= '0;
      a1b2  <= '0;
      a2b1  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a1_q <= a1;
        a2_q <= a2;
        b1_q <= b1;
        b2_q <= b2;
        idx  <= '0;
      end else if (state == MUL) begin
        idx <= idx + 2'd1;
      end
      // Products only move while multiplying, so DONE holds them steady
      if (state == MUL) begin
        case (idx)
          IDX_A1B1: a1b1 <= mul_p;
          IDX_A2B2: a2b2 <= mul_p;
          IDX_A1B2: a1b2 <= mul_p;
          IDX_A2B1: a2b1 <= mul_p;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmplx_partial_products.sv
// Directed bench for cmplx_partial_products with an expected-result queue.
module tb_cmplx_partial_products;
  import cmplx_fx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a1 = '0, a2 = '0, b1 = '0, b2 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a1b1, a2b2, a1b2, a2b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  state_t      dbg_state;

  always #5 clk = ~clk;

  cmplx_partial_products dut (
    .clk       (clk),
    .rst       (rst),
    .a1        (a1),
    .a2        (a2),
    .b1        (b1),
    .b2        (b2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1b1      (a1b1),
    .a2b2      (a2b2),
    .a1b2      (a1b2),
    .a2b1      (a2b1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // Scoreboard: {a1b1, a2b2, a1b2, a2b1}
  logic [127:0] exp_q[$];
  logic [127:0] pend_exp;
  int           n_cmp = 0;
  int           n_err = 0;

  // Values sampled at the most recent negedge
  logic         ov_s, ir_s, acc_flag;
  logic [127:0] prod_s;
  state_t       st_s;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] model(input logic [15:0] x1, input logic [15:0] x2,
                                         input logic [15:0] y1, input logic [15:0] y2);
    logic signed [31:0] p0, p1, p2, p3;
    p0 = $signed(x1) * $signed(y1);
    p1 = $signed(x2) * $signed(y2);
    p2 = $signed(x1) * $signed(y2);
    p3 = $signed(x2) * $signed(y1);
    return {p0, p1, p2, p3};
  endfunction

  // One clock: sample at negedge, retire/launch scoreboard entries, step past posedge
  task automatic cycle();
    @(negedge clk);
    ov_s     = out_valid;
    ir_s     = in_ready;
    prod_s   = {a1b1, a2b2, a1b2, a2b1};
    st_s     = dbg_state;
    acc_flag = in_valid && in_ready && rst;
    if (ov_s && out_ready && rst) begin
      chk("output_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) chk("products", prod_s, exp_q.pop_front());
    end
    if (acc_flag) exp_q.push_back(pend_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x1, input logic [15:0] x2,
                      input logic [15:0] y1, input logic [15:0] y2,
                      input logic [127:0] e, output int waited);
    a1 = x1; a2 = x2; b1 = y1; b2 = y2;
    in_valid = 1'b1;
    pend_exp = e;
    waited   = 0;
    acc_flag = 1'b0;
    while (!acc_flag && waited < 30) begin
      cycle();
      waited++;
    end
    chk("accept_in_time", 128'(acc_flag), 128'd1);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    cycle();
    while (!ov_s && k < 20) begin
      k++;
      cycle();
    end
  endtask

  initial begin
    int w, k;
    logic [15:0] r1, r2, r3, r4;

    // Reset
    rst = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    chk("reset_out_valid", 128'(ov_s), 128'd0);
    chk("reset_in_ready", 128'(ir_s), 128'd1);
    chk("reset_products", prod_s, 128'd0);
    chk("reset_state", 128'(st_s), 128'(IDLE));

    // 1) Basic transaction and latency
    out_ready = 1'b1;
    send(16'h0C00, 16'hF000, 16'h0400, 16'h1800,
         {32'h0030_0000, 32'hFE80_0000, 32'h0120_0000, 32'hFFC0_0000}, w);
    in_valid = 1'b0;
    wait_valid(k);
    chk("latency_basic", 128'(k), 128'd4);

    // 2) Extremes
    send(16'h8000, 16'h8000, 16'h8000, 16'h8000, {4{32'h4000_0000}}, w);
    in_valid = 1'b0;
    wait_valid(k);
    chk("latency_min", 128'(k), 128'd4);
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, {4{32'h3FFF_0001}}, w);
    in_valid = 1'b0;
    wait_valid(k);
    chk("latency_max", 128'(k), 128'd4);

    // 3) Downstream stall with a pending input
    out_ready = 1'b0;
    send(16'h0A00, 16'hFC00, 16'hE800, 16'h0333, model(16'h0A00, 16'hFC00, 16'hE800, 16'h0333), w);
    in_valid = 1'b0;
    wait_valid(k);
    chk("latency_stall", 128'(k), 128'd4);
    a1 = 16'h1234; a2 = 16'hFEDC; b1 = 16'h0F0F; b2 = 16'hA5A5;
    pend_exp = model(16'h1234, 16'hFEDC, 16'h0F0F, 16'hA5A5);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("stall_out_valid", 128'(ov_s), 128'd1);
      chk("stall_in_ready", 128'(ir_s), 128'd0);
      chk("stall_no_accept", 128'(acc_flag), 128'd0);
      chk("stall_products", prod_s, exp_q[0]);
    end
    out_ready = 1'b1;
    cycle();
    chk("release_accept", 128'(acc_flag), 128'd1);
    chk("release_queue", 128'(exp_q.size()), 128'd1);
    in_valid = 1'b0;
    wait_valid(k);
    chk("latency_after_stall", 128'(k), 128'd4);

    // 4) Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      r1 = 16'($urandom_range(0, 65535));
      r2 = 16'($urandom_range(0, 65535));
      r3 = 16'($urandom_range(0, 65535));
      r4 = 16'($urandom_range(0, 65535));
      send(r1, r2, r3, r4, model(r1, r2, r3, r4), w);
      if (i > 0) chk("stream_interval", 128'(w), 128'd5);
    end
    in_valid = 1'b0;
    wait_valid(k);
    chk("stream_tail_latency", 128'(k), 128'd4);

    // 5) Reset while multiplying idx2
    send(16'h0800, 16'h0800, 16'h0800, 16'h0800, model(16'h0800, 16'h0800, 16'h0800, 16'h0800), w);
    in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("pre_reset_state", 128'(st_s), 128'(MUL));
    exp_q.delete();
    rst = 1'b1;
    cycle();
    chk("midreset_out_valid", 128'(ov_s), 128'd0);
    chk("midreset_products", prod_s, 128'd0);
    chk("midreset_in_ready", 128'(ir_s), 128'd1);
    chk("midreset_state", 128'(st_s), 128'(IDLE));
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("no_stale_output", 128'(ov_s), 128'd0);
    end
    send(16'hF400, 16'h0200, 16'h0C00, 16'hFF00, model(16'hF400, 16'h0200, 16'h0C00, 16'hFF00), w);
    in_valid = 1'b0;
    wait_valid(k);
    chk("latency_after_reset", 128'(k), 128'd4);

    // 6) Ports change after acceptance
    send(16'h0400, 16'hFC00, 16'h2000, 16'hE000, model(16'h0400, 16'hFC00, 16'h2000, 16'hE000), w);
    in_valid = 1'b0;
    a1 = 16'h7FFF; a2 = 16'h8000; b1 = 16'h5555; b2 = 16'hAAAA;
    wait_valid(k);
    chk("latency_port_change", 128'(k), 128'd4);

    repeat (3) cycle();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
